alarm_kontrol: RTL and testbench

- Sits directly downstream of the temperature averaging/alarm stage.
- Consumes its registered alarm flag and average temperature.
- Turns raw alarm flags into an operator-facing alarm: confirms the alarm over consecutive samples, drives a blinking siren and steady LED, and supports a timed silence. Clears only after a sustained quiet period.
- Records the peak average temperature of each event and counts confirmed events.

---
 rtl/alarm_kontrol.sv | 155 +++++++++++++++
 tb/tb_alarm_kontrol.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_kontrol.sv
// alarm_kontrol: turns the upstream per-sample alarm flag into an operator alarm.
// An event is confirmed after ONAY_SAYISI consecutive highs. While ringing, the
// siren blinks and the LED stays on. A timed silence can be requested. The alarm
// clears only after TEMIZ_SAYISI consecutive lows. The block also tracks the peak
// average temperature of each event and counts confirmed events, saturating at 255.
module alarm_kontrol #(
    parameter int W               = 7,
    parameter int ONAY_SAYISI     = 3,
    parameter int TEMIZ_SAYISI    = 4,
    parameter int YANIP_SONME     = 2,
    parameter int SUSTURMA_SURESI = 8
) (
    input  logic         saat,
    input  logic         reset,
    input  logic         alarm_cal,
    input  logic [W-1:0] ortalama_sicaklik,
    input  logic         susturma,
    output logic         siren,
    output logic         led,
    output logic [1:0]   durum,
    output logic [W-1:0] tepe_sicaklik,
    output logic [7:0]   olay_sayaci
);

    typedef enum logic [1:0] {
        BEKLE   = 2'b00,
        DOGRULA = 2'b01,
        CALIYOR = 2'b10,
        SUSTUR  = 2'b11
    } durum_t;

    localparam logic [3:0] ONAY_SON  = 4'(ONAY_SAYISI - 1);
    localparam logic [3:0] TEMIZ_SON = 4'(TEMIZ_SAYISI - 1);
    localparam logic [3:0] FAZ_SON   = 4'(YANIP_SONME - 1);
    localparam logic [7:0] SUS_SON   = 8'(SUSTURMA_SURESI - 1);

    durum_t     durum_r;
    logic [3:0] onay_sayac;
    logic [3:0] temiz_sayac;
    logic [3:0] faz;
    logic [7:0] sus_sayac;

    logic       temizlendi;

    // The TEMIZ_SAYISI-th consecutive low is being sampled on this edge.
    always_comb begin
        temizlendi = 1'b0;
        if (!alarm_cal && (temiz_sayac == TEMIZ_SON)) begin
            temizlendi = 1'b1;
        end
    end

    assign durum = durum_r;

    // Alarm state machine. All outputs and internal counters are registered here.
    always_ff @(posedge saat) begin
        if (reset) begin
            durum_r       <= BEKLE;
            siren         <= 1'b0;
            led           <= 1'b0;
            tepe_sicaklik <= '0;
            olay_sayaci   <= '0;
            onay_sayac    <= '0;
            temiz_sayac   <= '0;
            faz           <= '0;
            sus_sayac     <= '0;
        end else begin
            case (durum_r)
                BEKLE: begin
                    siren <= 1'b0;
                    led   <= 1'b0;
                    if (alarm_cal) begin
                        durum_r    <= DOGRULA;
                        onay_sayac <= 4'd1;
                    end
                end

                DOGRULA: begin
                    siren <= 1'b0;
                    led   <= 1'b0;
                    if (!alarm_cal) begin
                        durum_r    <= BEKLE;
                        onay_sayac <= '0;
                    end else if (onay_sayac == ONAY_SON) begin
                        durum_r       <= CALIYOR;
                        onay_sayac    <= '0;
                        tepe_sicaklik <= ortalama_sicaklik;
                        siren         <= 1'b1;
                        led           <= 1'b1;
                        faz           <= '0;
                        temiz_sayac   <= '0;
                        if (olay_sayaci != 8'hFF) begin
                            olay_sayaci <= olay_sayaci + 8'd1;
                        end
                    end else begin
                        onay_sayac <= onay_sayac + 4'd1;
                    end
                end

                CALIYOR: begin
                    led <= 1'b1;
                    if (ortalama_sicaklik > tepe_sicaklik) begin
                        tepe_sicaklik <= ortalama_sicaklik;
                    end
                    temiz_sayac <= alarm_cal ? 4'd0 : temiz_sayac + 4'd1;
                    if (susturma) begin
                        durum_r   <= SUSTUR;
                        siren     <= 1'b0;
                        sus_sayac <= '0;
                    end else if (temizlendi) begin
                        durum_r     <= BEKLE;
                        siren       <= 1'b0;
                        led         <= 1'b0;
                        temiz_sayac <= '0;
                    end else if (faz == FAZ_SON) begin
                        faz   <= '0;
                        siren <= ~siren;
                    end else begin
                        faz <= faz + 4'd1;
                    end
                end

                SUSTUR: begin
                    siren <= 1'b0;
                    led   <= 1'b1;
                    if (ortalama_sicaklik > tepe_sicaklik) begin
                        tepe_sicaklik <= ortalama_sicaklik;
                    end
                    temiz_sayac <= alarm_cal ? 4'd0 : temiz_sayac + 4'd1;
                    if (temizlendi) begin
                        durum_r     <= BEKLE;
                        led         <= 1'b0;
                        temiz_sayac <= '0;
                    end else if (susturma) begin
                        sus_sayac <= '0;
                    end else if (sus_sayac == SUS_SON) begin
                        // Re-ring of the same event: peak and event count are kept.
                        durum_r <= CALIYOR;
                        siren   <= 1'b1;
                        faz     <= '0;
                    end else begin
                        sus_sayac <= sus_sayac + 8'd1;
                    end
                end

                default: begin
                    durum_r <= BEKLE;
                    siren   <= 1'b0;
                    led     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_kontrol.sv
// Directed bench for alarm_kontrol with default parameters.
// Each step drives the inputs and queues the outputs expected after the next edge.
// After the edge, the bench pops that entry and compares it against the DUT outputs.
module tb_alarm_kontrol;

    logic       saat = 1'b0;
    logic       reset;
    logic       alarm_cal;
    logic [6:0] ortalama_sicaklik;
    logic       susturma;
    logic       siren;
    logic       led;
    logic [1:0] durum;
    logic [6:0] tepe_sicaklik;
    logic [7:0] olay_sayaci;

    alarm_kontrol #(
        .W(7),
        .ONAY_SAYISI(3),
        .TEMIZ_SAYISI(4),
        .YANIP_SONME(2),
        .SUSTURMA_SURESI(8)
    ) dut (
        .saat(saat),
        .reset(reset),
        .alarm_cal(alarm_cal),
        .ortalama_sicaklik(ortalama_sicaklik),
        .susturma(susturma),
        .siren(siren),
        .led(led),
        .durum(durum),
        .tepe_sicaklik(tepe_sicaklik),
        .olay_sayaci(olay_sayaci)
    );

    always #5 saat = ~saat;

    // Check-select bits: durum, siren, led, tepe, olay.
    localparam logic [4:0] C_ALL  = 5'b11111;
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_DSL  = 5'b11100;
    localparam logic [4:0] C_DO   = 5'b10001;
    localparam logic [4:0] C_D    = 5'b10000;

    typedef struct packed {
        logic [1:0] d;
        logic       si;
        logic       le;
        logic [6:0] tp;
        logic [7:0] ol;
        logic [4:0] chk;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic step(input logic r, input logic a, input logic s, input logic [6:0] t,
                        input string tag, input logic [1:0] d, input logic si,
                        input logic le, input logic [6:0] tp, input logic [7:0] ol,
                        input logic [4:0] chk);
        exp_t  e;
        string tg;
        reset             = r;
        alarm_cal         = a;
        susturma          = s;
        ortalama_sicaklik = t;
        e.d = d; e.si = si; e.le = le; e.tp = tp; e.ol = ol; e.chk = chk;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge saat);
        #1;
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        if (e.chk[4]) begin
            n_tests++;
            assert (durum === e.d) else begin
                n_fail++;
                $error("FAIL %s durum: got %0d expected %0d", tg, durum, e.d);
            end
        end
        if (e.chk[3]) begin
            n_tests++;
            assert (siren === e.si) else begin
                n_fail++;
                $error("FAIL %s siren: got %0d expected %0d", tg, siren, e.si);
            end
        end
        if (e.chk[2]) begin
            n_tests++;
            assert (led === e.le) else begin
                n_fail++;
                $error("FAIL %s led: got %0d expected %0d", tg, led, e.le);
            end
        end
        if (e.chk[1]) begin
            n_tests++;
            assert (tepe_sicaklik === e.tp) else begin
                n_fail++;
                $error("FAIL %s tepe: got %0d expected %0d", tg, tepe_sicaklik, e.tp);
            end
        end
        if (e.chk[0]) begin
            n_tests++;
            assert (olay_sayaci === e.ol) else begin
                n_fail++;
                $error("FAIL %s olay: got %0d expected %0d", tg, olay_sayaci, e.ol);
            end
        end
    endtask

    initial begin
        reset = 1'b1; alarm_cal = 1'b0; susturma = 1'b0; ortalama_sicaklik = '0;

        // Reset with arbitrary inputs active.
        step(1, 1, 1, 7'd99, "reset0", 2'b00, 0, 0, 7'd0, 8'd0, C_ALL);
        step(1, 1, 1, 7'd99, "reset1", 2'b00, 0, 0, 7'd0, 8'd0, C_ALL);

        // Glitch rejection: 1,1,0,1,1,1.
        step(0, 1, 0, 7'd30, "glitch1", 2'b01, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd30, "glitch2", 2'b01, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 0, 0, 7'd30, "glitch3", 2'b00, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd30, "glitch4", 2'b01, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd30, "glitch5", 2'b01, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd40, "confirm1", 2'b10, 1, 1, 7'd40, 8'd1, C_ALL);

        // Peak tracking and siren blink in CALIYOR.
        step(0, 1, 0, 7'd45, "peak45", 2'b10, 1, 1, 7'd45, 8'd1, C_ALL);
        step(0, 1, 0, 7'd43, "peak43", 2'b10, 0, 1, 7'd45, 8'd1, C_ALL);
        step(0, 1, 0, 7'd50, "peak50", 2'b10, 0, 1, 7'd50, 8'd1, C_ALL);
        step(0, 1, 0, 7'd48, "peak48", 2'b10, 1, 1, 7'd50, 8'd1, C_ALL);

        // Clear after 4 lows; the peak is held afterward.
        step(0, 0, 0, 7'd20, "clr1", 2'b10, 1, 1, 7'd50, 8'd1, C_ALL);
        step(0, 0, 0, 7'd20, "clr2", 2'b10, 0, 1, 7'd50, 8'd1, C_ALL);
        step(0, 0, 0, 7'd20, "clr3", 2'b10, 0, 1, 7'd50, 8'd1, C_ALL);
        step(0, 0, 0, 7'd20, "clr4", 2'b00, 0, 0, 7'd50, 8'd1, C_ALL);
        step(0, 0, 0, 7'd10, "hold", 2'b00, 0, 0, 7'd50, 8'd1, C_ALL);

        // Silence and re-ring.
        step(0, 1, 0, 7'd25, "ev2a", 2'b01, 0, 0, 7'd50, 8'd1, C_ALL);
        step(0, 1, 0, 7'd25, "ev2b", 2'b01, 0, 0, 7'd50, 8'd1, C_ALL);
        step(0, 1, 0, 7'd25, "ev2c", 2'b10, 1, 1, 7'd25, 8'd2, C_ALL);
        step(0, 1, 1, 7'd25, "silence", 2'b11, 0, 1, 7'd25, 8'd2, C_ALL);
        for (int k = 1; k <= 7; k++) begin
            step(0, 1, 0, (k == 3) ? 7'd60 : 7'd25, "sus_wait", 2'b11, 0, 1,
                 (k >= 3) ? 7'd60 : 7'd25, 8'd2, C_ALL);
        end
        step(0, 1, 0, 7'd25, "rering", 2'b10, 1, 1, 7'd60, 8'd2, C_ALL);
        step(0, 1, 0, 7'd25, "rering2", 2'b10, 1, 1, 7'd60, 8'd2, C_ALL);

        // Silence cut short by clear.
        step(0, 1, 1, 7'd25, "sil2", 2'b11, 0, 1, 7'd60, 8'd2, C_ALL);
        step(0, 0, 0, 7'd25, "scut1", 2'b11, 0, 1, 7'd60, 8'd2, C_DSL);
        step(0, 0, 0, 7'd25, "scut2", 2'b11, 0, 1, 7'd60, 8'd2, C_DSL);
        step(0, 0, 0, 7'd25, "scut3", 2'b11, 0, 1, 7'd60, 8'd2, C_DSL);
        step(0, 0, 0, 7'd25, "scut4", 2'b00, 0, 0, 7'd60, 8'd2, C_ALL);

        // Clear counter restarts on an intervening high (0,0,0,1,0,0,0,0).
        // A silence request on the first low restarts the silence timer so it cannot expire.
        step(0, 1, 0, 7'd33, "ev3a", 2'b01, 0, 0, 7'd0, 8'd0, C_D);
        step(0, 1, 0, 7'd33, "ev3b", 2'b01, 0, 0, 7'd0, 8'd0, C_D);
        step(0, 1, 0, 7'd33, "ev3c", 2'b10, 1, 1, 7'd33, 8'd3, C_ALL);
        step(0, 1, 1, 7'd33, "sil3", 2'b11, 0, 1, 7'd33, 8'd3, C_ALL);
        step(0, 0, 1, 7'd33, "rst_pat1", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 0, 0, 7'd33, "rst_pat2", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 0, 0, 7'd33, "rst_pat3", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 1, 0, 7'd33, "rst_pat4", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 0, 0, 7'd33, "rst_pat5", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 0, 0, 7'd33, "rst_pat6", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 0, 0, 7'd33, "rst_pat7", 2'b11, 0, 1, 7'd0, 8'd0, C_DSL);
        step(0, 0, 0, 7'd33, "rst_pat8", 2'b00, 0, 0, 7'd33, 8'd3, C_ALL);

        // Saturation: confirmed events 4 through 257.
        for (int i = 4; i <= 257; i++) begin
            step(0, 1, 0, 7'd33, "sat_h1", 2'b01, 0, 0, 7'd0, 8'd0, C_NONE);
            step(0, 1, 0, 7'd33, "sat_h2", 2'b01, 0, 0, 7'd0, 8'd0, C_NONE);
            step(0, 1, 0, 7'd33, "sat_ev", 2'b10, 0, 0, 7'd0,
                 (i > 255) ? 8'd255 : 8'(i), C_DO);
            step(0, 0, 0, 7'd33, "sat_l1", 2'b00, 0, 0, 7'd0, 8'd0, C_NONE);
            step(0, 0, 0, 7'd33, "sat_l2", 2'b00, 0, 0, 7'd0, 8'd0, C_NONE);
            step(0, 0, 0, 7'd33, "sat_l3", 2'b00, 0, 0, 7'd0, 8'd0, C_NONE);
            step(0, 0, 0, 7'd33, "sat_l4", 2'b00, 0, 0, 7'd0, 8'd0, C_D);
        end

        // Reset in the middle of an event.
        step(0, 1, 0, 7'd70, "mr_a", 2'b01, 0, 0, 7'd0, 8'd0, C_D);
        step(0, 1, 0, 7'd70, "mr_b", 2'b01, 0, 0, 7'd0, 8'd0, C_D);
        step(0, 1, 0, 7'd70, "mr_ev", 2'b10, 1, 1, 7'd70, 8'd255, C_ALL);
        step(1, 1, 1, 7'd70, "mid_reset", 2'b00, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 0, 0, 7'd70, "post_reset", 2'b00, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd15, "pr_a", 2'b01, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd15, "pr_b", 2'b01, 0, 0, 7'd0, 8'd0, C_ALL);
        step(0, 1, 0, 7'd15, "pr_ev", 2'b10, 1, 1, 7'd15, 8'd1, C_ALL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
